// File: rtl/alu_mdu_pkg.sv
// Shared op codes and FSM state encoding for the alu_mdu execute unit.
// ALU_MDU_DIV_EN adds the DIV state used by the iterative divider.
package alu_mdu_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_ADD    = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB    = 5'd1;
  localparam logic [OP_W-1:0] OP_XOR    = 5'd2;
  localparam logic [OP_W-1:0] OP_OR     = 5'd3;
  localparam logic [OP_W-1:0] OP_AND    = 5'd4;
  localparam logic [OP_W-1:0] OP_SLL    = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL    = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA    = 5'd7;
  localparam logic [OP_W-1:0] OP_SLT    = 5'd8;
  localparam logic [OP_W-1:0] OP_SLTU   = 5'd9;
  localparam logic [OP_W-1:0] OP_LUI    = 5'd10;
  localparam logic [OP_W-1:0] OP_AUIPC  = 5'd11;
  localparam logic [OP_W-1:0] OP_MUL    = 5'd12;
  localparam logic [OP_W-1:0] OP_MULH   = 5'd13;
  localparam logic [OP_W-1:0] OP_MULHSU = 5'd14;
  localparam logic [OP_W-1:0] OP_MULHU  = 5'd15;
  localparam logic [OP_W-1:0] OP_DIV    = 5'd16;
  localparam logic [OP_W-1:0] OP_DIVU   = 5'd17;
  localparam logic [OP_W-1:0] OP_REM    = 5'd18;
  localparam logic [OP_W-1:0] OP_REMU   = 5'd19;

  localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 5'd20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MDU_DIV_EN
    ST_DIV  = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mdu_div_iter.sv
// Unsigned restoring divider: one quotient bit per cycle, XLEN cycles total.
// The first step is taken on the start edge so done rises XLEN-1 cycles later.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   count;
  logic [XLEN-1:0] dvsr;
  logic [XLEN-1:0] src_q;
  logic [XLEN-1:0] src_r;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] step_q;
  logic [XLEN-1:0] step_r;

  // One restoring step; on start it works straight from the input operands.
  always_comb begin
    src_q  = start ? dividend : quotient;
    src_r  = start ? '0 : remainder;
    rem_sh = {src_r, src_q[XLEN-1]};
    trial  = rem_sh - {1'b0, (start ? divisor : dvsr)};
    if (trial[XLEN]) begin
      step_r = rem_sh[XLEN-1:0];
      step_q = {src_q[XLEN-2:0], 1'b0};
    end else begin
      step_r = trial[XLEN-1:0];
      step_q = {src_q[XLEN-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      dvsr      <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      count     <= CW'(1);
      dvsr      <= divisor;
      quotient  <= step_q;
      remainder <= step_r;
    end else if (busy) begin
      quotient  <= step_q;
      remainder <= step_r;
      count     <= CW'(count + CW'(1));
      if (count == CW'(XLEN - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// RV32I ALU plus M-extension execute unit behind a valid/ready handshake.
// ALU_MDU_DIV_EN enables div/rem (ops 16-19); otherwise they report illegal.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter  int unsigned XLEN = 32,
  localparam int unsigned SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [SHW-1:0]  shamt,
  input  logic            b_sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int unsigned PW = 2 * XLEN;

  state_t                 state;
  logic                   accept;
  logic [SHW-1:0]         sh;
  logic signed [XLEN:0]   mul_a;
  logic signed [XLEN:0]   mul_b;
  logic signed [PW-1:0]   prod;
  logic [XLEN-1:0]        op_res;
  logic                   op_ill;

  assign in_ready = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign sh       = b_sel ? shamt : src_b[SHW-1:0];

  // Operand sign-extension selects signed/unsigned halves of the product.
  assign mul_a = {((op == OP_MULH) || (op == OP_MULHSU)) & src_a[XLEN-1], src_a};
  assign mul_b = {(op == OP_MULH) & src_b[XLEN-1], src_b};
  assign prod  = PW'(mul_a) * PW'(mul_b);

`ifdef ALU_MDU_DIV_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            div_op, div_sgn, div_rem, a_neg, b_neg, b_zero, div_ovf, go_div;
  logic [XLEN-1:0] a_mag, b_mag, div_q, div_r, div_res;
  logic            div_busy, div_done;
  logic            q_neg, r_neg, rem_sel;

  assign div_op  = (op >= OP_DIV) && (op <= OP_REMU);
  assign div_sgn = (op == OP_DIV) || (op == OP_REM);
  assign div_rem = (op == OP_REM) || (op == OP_REMU);
  assign a_neg   = div_sgn & src_a[XLEN-1];
  assign b_neg   = div_sgn & src_b[XLEN-1];
  assign a_mag   = a_neg ? -src_a : src_a;
  assign b_mag   = b_neg ? -src_b : src_b;
  assign b_zero  = (src_b == '0);
  assign div_ovf = div_sgn && (src_a == SMIN) && (src_b == '1);
  assign go_div  = div_op && !b_zero && !div_ovf;
  assign div_res = rem_sel ? (r_neg ? -div_r : div_r) : (q_neg ? -div_q : div_q);

  div_iter #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && go_div),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  // Single-cycle result; div/rem entries only cover the zero and overflow cases.
  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (op)
      OP_ADD, OP_AUIPC: op_res = src_a + src_b;
      OP_SUB:           op_res = src_a - src_b;
      OP_XOR:           op_res = src_a ^ src_b;
      OP_OR:            op_res = src_a | src_b;
      OP_AND:           op_res = src_a & src_b;
      OP_SLL:           op_res = src_a << sh;
      OP_SRL:           op_res = src_a >> sh;
      OP_SRA:           op_res = XLEN'($signed(src_a) >>> sh);
      OP_SLT:           op_res = XLEN'($signed(src_a) < $signed(src_b));
      OP_SLTU:          op_res = XLEN'(src_a < src_b);
      OP_LUI:           op_res = src_b;
      OP_MUL:           op_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: op_res = prod[PW-1:XLEN];
`ifdef ALU_MDU_DIV_EN
      OP_DIV, OP_DIVU:  op_res = b_zero ? '1 : src_a;
      OP_REM, OP_REMU:  op_res = b_zero ? src_a : '0;
`endif
      default:          op_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      illegal   <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      rem_sel   <= 1'b0;
`endif
    end else if (accept) begin
      result    <= op_res;
      illegal   <= op_ill;
      out_valid <= 1'b1;
      state     <= ST_DONE;
`ifdef ALU_MDU_DIV_EN
      q_neg     <= a_neg ^ b_neg;
      r_neg     <= a_neg;
      rem_sel   <= div_rem;
      if (go_div) begin
        out_valid <= 1'b0;
        state     <= ST_DIV;
      end
`endif
    end else if ((state == ST_DONE) && out_ready) begin
      out_valid <= 1'b0;
      state     <= ST_IDLE;
    end
`ifdef ALU_MDU_DIV_EN
    else if ((state == ST_DIV) && div_done && !div_busy) begin
      result    <= div_res;
      illegal   <= 1'b0;
      out_valid <= 1'b1;
      state     <= ST_DONE;
    end
`endif
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu; divide checks follow ALU_MDU_DIV_EN.
module tb_alu_mdu;
  import alu_mdu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op = 5'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        b_sel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  int   tag = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .shamt     (shamt),
    .b_sel     (b_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .illegal   (illegal)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Monitor: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("t%0d_result", e.tag), result, e.res);
        chk($sformatf("t%0d_illegal", e.tag), 32'(illegal), 32'(e.ill));
        if (e.lat != 0)
          chk($sformatf("t%0d_latency", e.tag), 32'(ncyc - e.acc - 1), 32'(e.lat));
      end
    end
  end

  // lat = 0 skips the latency comparison (used while out_ready is held low).
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic bs, input logic [4:0] sh,
                       input logic [31:0] er, input logic ei, input int lat);
    int guard = 0;
    op = o; src_a = a; src_b = b; b_sel = bs; shamt = sh; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    tag++;
    sb.push_back('{er, ei, lat, ncyc, tag});
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h0;
    op = 5'd0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int lows;
    int highs;
    int g;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back single-cycle ops with out_ready held high.
    issue(OP_ADD,    32'h7FFF_FFFF, 32'h1,         1'b0, 5'd0, 32'h8000_0000, 1'b0, 1);
    chk("in_ready_streaming", 32'(in_ready), 32'd1);
    issue(OP_SUB,    32'd5,         32'd7,         1'b0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1);
    issue(OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5'd0, 32'h0FF0_0FF0, 1'b0, 1);
    issue(OP_OR,     32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5'd0, 32'hFFF0_FFF0, 1'b0, 1);
    issue(OP_AND,    32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 5'd0, 32'hF000_F000, 1'b0, 1);
    issue(OP_SLL,    32'h1,         32'd31,        1'b0, 5'd0, 32'h8000_0000, 1'b0, 1);
    issue(OP_SLL,    32'hFF,        32'd3,         1'b1, 5'd8, 32'h0000_FF00, 1'b0, 1);
    issue(OP_SRL,    32'h8000_0000, 32'h0,         1'b1, 5'd4, 32'h0800_0000, 1'b0, 1);
    issue(OP_SRA,    32'h8000_0000, 32'h0,         1'b1, 5'd4, 32'hF800_0000, 1'b0, 1);
    issue(OP_SRA,    32'h8000_0000, 32'h24,        1'b0, 5'd0, 32'hF800_0000, 1'b0, 1);
    issue(OP_SLT,    32'hFFFF_FFFF, 32'h1,         1'b0, 5'd0, 32'h1,         1'b0, 1);
    issue(OP_SLTU,   32'hFFFF_FFFF, 32'h1,         1'b0, 5'd0, 32'h0,         1'b0, 1);
    issue(OP_LUI,    32'h5555_5555, 32'h1234_5000, 1'b0, 5'd0, 32'h1234_5000, 1'b0, 1);
    issue(OP_AUIPC,  32'h1000,      32'h2000,      1'b0, 5'd0, 32'h3000,      1'b0, 1);
    issue(OP_MUL,    32'h3,         32'hFFFF_FFFE, 1'b0, 5'd0, 32'hFFFF_FFFA, 1'b0, 1);
    issue(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         1'b0, 1);
    issue(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'hFFFF_FFFE, 1'b0, 1);
    issue(5'd25,     32'h1234_5678, 32'h9,         1'b0, 5'd0, 32'h0,         1'b1, 1);
    issue(5'd31,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0,         1'b1, 1);
    drain();

    // Consumer stall: result must hold while out_ready is low.
    out_ready = 1'b0;
    issue(OP_ADD, 32'd1, 32'd2, 1'b0, 5'd0, 32'd3, 1'b0, 0);
    g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_result", i), result, 32'd3);
      chk($sformatf("stall%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();

`ifdef ALU_MDU_DIV_EN
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd0, 32'hFFFF_FFFD, 1'b0, 33);
    lows = 0;
    for (int i = 0; i < 32; i++) begin
      if (!in_ready) lows++;
      @(posedge clk); #1;
    end
    chk("div_in_ready_low_cycles", 32'(lows), 32'd32);
    drain();
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2,         1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 33);
    issue(OP_DIVU, 32'd100,       32'd7,         1'b0, 5'd0, 32'd14,        1'b0, 33);
    issue(OP_REMU, 32'd100,       32'd7,         1'b0, 5'd0, 32'd2,         1'b0, 33);
    issue(OP_DIV,  32'd7,         32'hFFFF_FFFE, 1'b0, 5'd0, 32'hFFFF_FFFD, 1'b0, 33);
    issue(OP_REM,  32'd7,         32'hFFFF_FFFE, 1'b0, 5'd0, 32'd1,         1'b0, 33);
    issue(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0,         1'b0, 33);
    issue(OP_DIV,  32'd5,         32'd0,         1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP_REM,  32'd5,         32'd0,         1'b0, 5'd0, 32'd5,         1'b0, 1);
    issue(OP_DIVU, 32'd5,         32'd0,         1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1);
    issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h8000_0000, 1'b0, 1);
    issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0,         1'b0, 1);
    drain();

    // Abandon a divide partway through with reset.
    issue(OP_DIV, 32'd1000, 32'd3, 1'b0, 5'd0, 32'd333, 1'b0, 33);
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    highs = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) highs++;
    end
    chk("rst_mid_div_out_valid", 32'(highs), 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_div_in_ready", 32'(in_ready), 32'd1);
`else
    issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1);
    issue(OP_DIVU, 32'd100,       32'd7, 1'b0, 5'd0, 32'h0, 1'b1, 1);
    issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 1'b0, 5'd0, 32'h0, 1'b1, 1);
    issue(OP_REMU, 32'd100,       32'd0, 1'b0, 5'd0, 32'h0, 1'b1, 1);
    drain();
`endif

    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
